audio_dma_slot: RTL and testbench

//  Per-scanline DMA sequencer for audio channel 0; sits directly upstream of the audio mixer.
//  On each line-start pulse it emits the mixer's dma_start/dma_end strobe pair.

---
 rtl/audio_dma_slot_if.sv | 23 ++
 rtl/audio_dma_slot.sv | 224 ++++++++++++++++++++++
 tb/tb_audio_dma_slot.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_dma_slot_if.sv
// VRAM read bus between the audio DMA slot sequencer (master) and the
// VRAM arbiter (slave). The request is a level that is held until acked.
// Read data arrives a fixed number of cycles after the ack.
interface audio_dma_slot_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/audio_dma_slot.sv
// audio_dma_slot: per-scanline DMA sequencer for audio channel 0.
// Each enabled line-start pulse produces one dma_start/dma_end strobe pair
// toward the mixer. Between the strobes at most one VRAM word is read on the
// mixer's behalf, and that word is presented on word_o together with dma_end.
//
// Optional feature macro: AUDIO_DMA_TIMEOUT_EN
//   defined   -> a request left unacked for ACK_TIMEOUT cycles is abandoned.
//                word_o is then forced to silence and underrun_o is set sticky.
//   undefined -> a request waits for its ack indefinitely and underrun_o is 0.
module audio_dma_slot #(
    parameter int SLOT_DELAY  = 4,
    parameter int RD_LATENCY  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_ni,
    input  logic                      audio_enable_i,
    input  logic                      line_start_i,
    input  logic                      fetch_req_i,
    input  logic [15:0]               fetch_addr_i,
    output logic                      dma_start_o,
    output logic                      dma_end_o,
    output logic [15:0]               word_o,
    output logic                      missed_o,
    output logic                      underrun_o,
    audio_dma_slot_if.master          mem
);

    // Parameters outside the supported ranges must not elaborate: all
    // counters are 4 bits wide.
    generate
        if ((SLOT_DELAY < 1) || (SLOT_DELAY > 15)) begin : g_bad_slot_delay
            $error("audio_dma_slot: SLOT_DELAY must be within 1..15");
        end
        if ((RD_LATENCY < 1) || (RD_LATENCY > 7)) begin : g_bad_rd_latency
            $error("audio_dma_slot: RD_LATENCY must be within 1..7");
        end
        if ((ACK_TIMEOUT < 1) || (ACK_TIMEOUT > 16)) begin : g_bad_ack_timeout
            $error("audio_dma_slot: ACK_TIMEOUT must be within 1..16");
        end
    endgenerate

    // Countdown loads: the state is left when the counter reads zero, so
    // loading N-1 spends exactly N cycles in DELAY or LAT.
    localparam logic [3:0] SLOT_LOAD = 4'(SLOT_DELAY - 1);
    localparam logic [3:0] RD_LOAD   = 4'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DELAY  = 3'd1,
        S_START  = 3'd2,
        S_SAMPLE = 3'd3,
        S_REQ    = 3'd4,
        S_LAT    = 3'd5,
        S_END    = 3'd6
    } state_e;

    state_e      state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic        dma_start_q, dma_start_d;
    logic        dma_end_q,   dma_end_d;
    logic [15:0] word_q,      word_d;
    logic        mem_req_q,   mem_req_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic        missed_q,    missed_d;

`ifdef AUDIO_DMA_TIMEOUT_EN
    // The request is abandoned at the end of its ACK_TIMEOUT-th cycle, so
    // the counter only needs to reach ACK_TIMEOUT-1 (fits in 4 bits).
    localparam logic [3:0] TO_LAST = 4'(ACK_TIMEOUT - 1);

    logic [3:0]  tcnt_q,      tcnt_d;
    logic        underrun_q,  underrun_d;
`endif

    // Next-state and next-output logic of the slot sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dma_start_d = 1'b0;
        dma_end_d   = 1'b0;
        word_d      = word_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        // A line start seen outside IDLE is dropped but reported next cycle.
        missed_d    = line_start_i && (state_q != S_IDLE);
`ifdef AUDIO_DMA_TIMEOUT_EN
        tcnt_d      = tcnt_q;
        underrun_d  = underrun_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Enable only gates entry; a disabled line start is silent.
                if (line_start_i && audio_enable_i) begin
                    state_d = S_DELAY;
                    cnt_d   = SLOT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_DELAY: begin
                if (cnt_q == 4'd0) begin
                    state_d     = S_START;
                    dma_start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_START: begin
                state_d = S_SAMPLE;
            end

            S_SAMPLE: begin
                // The mixer's fetch flag becomes visible one cycle after
                // dma_start, which is why it is sampled here and not in START.
                if (fetch_req_i) begin
                    mem_addr_d = fetch_addr_i;
                    mem_req_d  = 1'b1;
                    state_d    = S_REQ;
`ifdef AUDIO_DMA_TIMEOUT_EN
                    tcnt_d     = 4'd0;
`endif
                end else begin
                    state_d   = S_END;
                    dma_end_d = 1'b1;
                end
            end

            S_REQ: begin
                // An ack on the expiring cycle is checked first and wins.
                if (mem.mem_ack) begin
                    mem_req_d = 1'b0;
                    cnt_d     = RD_LOAD;
                    state_d   = S_LAT;
                end
`ifdef AUDIO_DMA_TIMEOUT_EN
                else if (tcnt_q == TO_LAST) begin
                    mem_req_d  = 1'b0;
                    word_d     = 16'h0000;
                    underrun_d = 1'b1;
                    state_d    = S_END;
                    dma_end_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 4'd1;
                end
`else
                else begin
                    mem_req_d = 1'b1;
                end
`endif
            end

            S_LAT: begin
                if (cnt_q == 4'd0) begin
                    word_d    = mem.mem_data;
                    state_d   = S_END;
                    dma_end_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_END: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; every output is driven from a flop.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            dma_start_q <= 1'b0;
            dma_end_q   <= 1'b0;
            word_q      <= 16'h0000;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 16'h0000;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dma_start_q <= dma_start_d;
            dma_end_q   <= dma_end_d;
            word_q      <= word_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            missed_q    <= missed_d;
        end
    end

`ifdef AUDIO_DMA_TIMEOUT_EN
    // Ack-timeout counter and sticky underrun flag (cleared by reset only).
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            tcnt_q     <= 4'd0;
            underrun_q <= 1'b0;
        end else begin
            tcnt_q     <= tcnt_d;
            underrun_q <= underrun_d;
        end
    end

    assign underrun_o = underrun_q;
`else
    assign underrun_o = 1'b0;
`endif

    assign dma_start_o  = dma_start_q;
    assign dma_end_o    = dma_end_q;
    assign word_o       = word_q;
    assign missed_o     = missed_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_audio_dma_slot.sv
// Testbench for audio_dma_slot. Each scanline transaction is predicted from
// the slot timing rules (offsets of the strobes, request length, captured
// word) and compared with what the DUT produced over a fixed window.
module tb_audio_dma_slot;

    localparam int SD = 4;
    localparam int RL = 2;
    localparam int AT = 16;
`ifdef AUDIO_DMA_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        audio_enable_i = 1'b0;
    logic        line_start_i = 1'b0;
    logic        fetch_req_i = 1'b0;
    logic [15:0] fetch_addr_i = 16'h0000;
    logic        dma_start_o;
    logic        dma_end_o;
    logic [15:0] word_o;
    logic        missed_o;
    logic        underrun_o;

    audio_dma_slot_if mem_if ();

    audio_dma_slot #(
        .SLOT_DELAY  (SD),
        .RD_LATENCY  (RL),
        .ACK_TIMEOUT (AT)
    ) dut (
        .clk            (clk),
        .reset_ni       (reset_ni),
        .audio_enable_i (audio_enable_i),
        .line_start_i   (line_start_i),
        .fetch_req_i    (fetch_req_i),
        .fetch_addr_i   (fetch_addr_i),
        .dma_start_o    (dma_start_o),
        .dma_end_o      (dma_end_o),
        .word_o         (word_o),
        .missed_o       (missed_o),
        .underrun_o     (underrun_o),
        .mem            (mem_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state carried between transactions.
    logic [15:0] exp_word = 16'h0000;
    logic        exp_underrun = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dma_start"}, 32'(dma_start_o), 32'd0);
        check({tag, "_dma_end"},   32'(dma_end_o),   32'd0);
        check({tag, "_word"},      32'(word_o),      32'd0);
        check({tag, "_mem_req"},   32'(mem_if.mem_req),  32'd0);
        check({tag, "_mem_addr"},  32'(mem_if.mem_addr), 32'd0);
        check({tag, "_missed"},    32'(missed_o),    32'd0);
        check({tag, "_underrun"},  32'(underrun_o),  32'd0);
    endtask

    // One scanline. Cycle 0 carries the line_start pulse; d is the number
    // of request cycles before the ack; ov (>0) adds a second line_start.
    task automatic run_txn(input string tag, input bit en, input bit fetch,
                           input logic [15:0] addr, input int d, input logic [15:0] data,
                           input int ov_in, input bit ov_rand, input bit drop_en);
        int t_start, t_req, t_ack, t_end, win, exp_req, ov, c;
        bit reads, timeout;
        int obs_start, obs_end, obs_missed;
        int n_start, n_end, n_both, n_req, n_addr_bad, n_missed;
        logic [15:0] word_at_end;

        // Expected timeline from the slot rules.
        t_start = SD + 1;
        t_req   = t_start + 2;
        t_ack   = -100;
        reads   = en && fetch;
        timeout = 1'b0;
        if (!en) begin
            t_end = -1;
        end else if (!fetch) begin
            t_end = t_start + 2;
        end else if (TO_EN && (d >= AT)) begin
            timeout = 1'b1;
            t_end   = t_req + AT;
        end else begin
            t_ack = t_req + d;
            t_end = t_ack + RL + 1;
        end
        exp_req = !reads ? 0 : (timeout ? AT : d + 1);
        win = (en ? t_end : t_start + 4) + 3;
        ov = ov_in;
        if (ov_rand && en) ov = $urandom_range(1, t_end);
        if (!en) ov = 0;

        obs_start = -1; obs_end = -1; obs_missed = -1;
        n_start = 0; n_end = 0; n_both = 0; n_req = 0; n_addr_bad = 0; n_missed = 0;
        word_at_end = 16'hxxxx;

        for (int k = 0; k < win; k++) begin
            line_start_i   = (k == 0) || ((ov > 0) && (k == ov));
            audio_enable_i = (k == 0) ? en : (drop_en ? 1'b0 : en);
            fetch_req_i    = (k == t_start + 1) ? fetch : 1'($urandom_range(0, 1));
            fetch_addr_i   = (k == t_start + 1) ? addr : 16'($urandom);
            mem_if.mem_ack = (reads && !timeout && (k == t_ack)) ||
                             ((k >= 1) && (k <= SD) && ($urandom_range(0, 1) == 1));
            mem_if.mem_data = (reads && !timeout && (k == t_ack + RL)) ? data : 16'($urandom);
            @(posedge clk);
            #1;
            c = k + 1;
            if (dma_start_o) begin n_start++; obs_start = c; end
            if (dma_end_o) begin n_end++; obs_end = c; word_at_end = word_o; end
            if (dma_start_o && dma_end_o) n_both++;
            if (mem_if.mem_req) begin
                n_req++;
                if (mem_if.mem_addr !== addr) n_addr_bad++;
            end
            if (missed_o) begin n_missed++; obs_missed = c; end
        end
        line_start_i   = 1'b0;
        mem_if.mem_ack = 1'b0;
        audio_enable_i = 1'b1;

        if (reads) exp_word = timeout ? 16'h0000 : data;
        if (timeout) exp_underrun = 1'b1;

        check({tag, "_n_start"}, 32'(n_start), en ? 32'd1 : 32'd0);
        check({tag, "_n_end"},   32'(n_end),   en ? 32'd1 : 32'd0);
        check({tag, "_both"},    32'(n_both),  32'd0);
        check({tag, "_req_cycles"}, 32'(n_req), 32'(exp_req));
        check({tag, "_addr_bad"},   32'(n_addr_bad), 32'd0);
        check({tag, "_n_missed"},   32'(n_missed), (ov > 0) ? 32'd1 : 32'd0);
        if (en) begin
            check({tag, "_start_cyc"}, 32'(obs_start), 32'(t_start));
            check({tag, "_end_cyc"},   32'(obs_end),   32'(t_end));
            check({tag, "_word_at_end"}, 32'(word_at_end), 32'(exp_word));
        end
        if (ov > 0) check({tag, "_missed_cyc"}, 32'(obs_missed), 32'(ov + 1));
        check({tag, "_word_hold"}, 32'(word_o), 32'(exp_word));
        check({tag, "_underrun"},  32'(underrun_o), 32'(exp_underrun));
    endtask

    // Safety net so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int n_strobe;
        bit en_r, fetch_r, ov_r, drop_r;
        int d_r;

        mem_if.mem_ack  = 1'b0;
        mem_if.mem_data = 16'h0000;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_ni = 1'b1;
        audio_enable_i = 1'b1;
        n_strobe = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (dma_start_o || dma_end_o || mem_if.mem_req) n_strobe++;
        end
        check("post_reset_quiet", 32'(n_strobe), 32'd0);

        // Directed scanlines.
        run_txn("normal",  1'b1, 1'b1, 16'h1234, 0, 16'hA55A, 0, 1'b0, 1'b0);
        run_txn("nofetch", 1'b1, 1'b0, 16'h5678, 0, 16'h1111, 0, 1'b0, 1'b0);
        run_txn("stall7",  1'b1, 1'b1, 16'h2468, 7, 16'h0F0F, 0, 1'b0, 1'b0);
        run_txn("ov_lat",  1'b1, 1'b1, 16'h3333, 0, 16'hC3C3, SD + 4, 1'b0, 1'b0);
        run_txn("ov_end",  1'b1, 1'b0, 16'h4444, 0, 16'h0000, SD + 3, 1'b0, 1'b0);
        run_txn("disabled", 1'b0, 1'b1, 16'h5555, 0, 16'hDEAD, 0, 1'b0, 1'b0);
        run_txn("drop_en", 1'b1, 1'b1, 16'h6666, 3, 16'h7E57, 0, 1'b0, 1'b1);
`ifdef AUDIO_DMA_TIMEOUT_EN
        run_txn("ack_at_expiry", 1'b1, 1'b1, 16'h7777, AT - 1, 16'h9A9A, 0, 1'b0, 1'b0);
        run_txn("timeout",       1'b1, 1'b1, 16'h8888, AT, 16'hFFFF, 0, 1'b0, 1'b0);
        run_txn("after_timeout", 1'b1, 1'b1, 16'h9999, 1, 16'h1357, 0, 1'b0, 1'b0);
`else
        run_txn("long_stall", 1'b1, 1'b1, 16'h7777, 105, 16'h9A9A, 0, 1'b0, 1'b0);
`endif

        // Reset asserted while the read is in its latency phase.
        audio_enable_i = 1'b1;
        fetch_req_i    = 1'b1;
        fetch_addr_i   = 16'hBEEF;
        line_start_i   = 1'b1;
        @(posedge clk);
        #1;
        line_start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; (i < 20) && !seen; i++) begin
            if (mem_if.mem_req) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("rst_req_seen", 32'(seen), 32'd1);
        mem_if.mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_if.mem_ack = 1'b0;
        #2;
        reset_ni = 1'b0;
        #1;
        check_all_zero("rst_mid_lat");
        exp_word = 16'h0000;
        exp_underrun = 1'b0;
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        n_strobe = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (dma_start_o || dma_end_o || mem_if.mem_req || missed_o) n_strobe++;
        end
        check("rst_no_strobes", 32'(n_strobe), 32'd0);

        // Randomized scanlines.
        for (int t = 0; t < 24; t++) begin
            en_r    = ($urandom_range(0, 4) != 0);
            fetch_r = ($urandom_range(0, 3) != 0);
            ov_r    = ($urandom_range(0, 2) == 0);
            drop_r  = ($urandom_range(0, 3) == 0);
            d_r     = TO_EN ? $urandom_range(0, AT + 2) : $urandom_range(0, 9);
            run_txn("rand", en_r, fetch_r, 16'($urandom), d_r, 16'($urandom), 0, ov_r, drop_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
